// File: rtl/ps2_pkg.sv
// Shared PS/2 constants, FSM encoding and small byte classification helpers.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT  = 8'hE0;
  localparam logic [7:0] PS2_BRK  = 8'hF0;
  localparam logic [7:0] PS2_ERR0 = 8'h00;
  localparam logic [7:0] PS2_ERR1 = 8'hFF;

  localparam logic [7:0] ASCII_NONE  = 8'h00;
  localparam logic [7:0] ASCII_ENTER = 8'h0D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    WAIT = 2'd2
  } ps2_state_e;

  // Keyboard error codes carry no key information.
  function automatic logic is_err_byte(input logic [7:0] b);
    return (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

  // Prefix bytes modify the following code rather than being keys themselves.
  function automatic logic is_prefix_byte(input logic [7:0] b);
    return (b == PS2_EXT) || (b == PS2_BRK);
  endfunction

endpackage

// File: rtl/ps2_scan2ascii.sv
// Combinational set-2 scan code to ASCII ROM; extended codes never map.
module ps2_scan2ascii
  import ps2_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output logic [7:0] ascii
);

  // Look up letters, digits, space and enter; everything else is unmapped.
  always_comb begin
    ascii = ASCII_NONE;
    if (ext) begin
      ascii = ASCII_NONE;
    end else begin
      case (code)
        8'h1C: ascii = 8'h61;  8'h32: ascii = 8'h62;  8'h21: ascii = 8'h63;
        8'h23: ascii = 8'h64;  8'h24: ascii = 8'h65;  8'h2B: ascii = 8'h66;
        8'h34: ascii = 8'h67;  8'h33: ascii = 8'h68;  8'h43: ascii = 8'h69;
        8'h3B: ascii = 8'h6A;  8'h42: ascii = 8'h6B;  8'h4B: ascii = 8'h6C;
        8'h3A: ascii = 8'h6D;  8'h31: ascii = 8'h6E;  8'h44: ascii = 8'h6F;
        8'h4D: ascii = 8'h70;  8'h15: ascii = 8'h71;  8'h2D: ascii = 8'h72;
        8'h1B: ascii = 8'h73;  8'h2C: ascii = 8'h74;  8'h3C: ascii = 8'h75;
        8'h2A: ascii = 8'h76;  8'h1D: ascii = 8'h77;  8'h22: ascii = 8'h78;
        8'h35: ascii = 8'h79;  8'h1A: ascii = 8'h7A;
        8'h45: ascii = 8'h30;  8'h16: ascii = 8'h31;  8'h1E: ascii = 8'h32;
        8'h26: ascii = 8'h33;  8'h25: ascii = 8'h34;  8'h2E: ascii = 8'h35;
        8'h36: ascii = 8'h36;  8'h3D: ascii = 8'h37;  8'h3E: ascii = 8'h38;
        8'h46: ascii = 8'h39;
        8'h29: ascii = 8'h20;
        8'h5A: ascii = ASCII_ENTER;
        default: ascii = ASCII_NONE;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// Pops scan-code bytes from the PS/2 FIFO, folds E0/F0 prefixes into single
// key events, filters typematic repeats and tracks the held key.
module ps2_key_event_decoder
  import ps2_pkg::*;
#(
  parameter bit SUPPRESS_REPEAT = 1'b1,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       data,
  input  logic             ready,
  input  logic             overflow,
  output logic             nextdata_n,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_break,
  output logic [7:0]       key_ascii,
  output logic             key_held,
  output logic [7:0]       held_code,
  output logic [CNT_W-1:0] make_count,
  output logic             ovf_sticky
);

  ps2_state_e       state_r;
  logic [7:0]       byte_r;
  logic             nextdata_n_r;
  logic             ext_pend_r;
  logic             brk_pend_r;
  logic             held_ext_r;
  logic             key_valid_r;
  logic [7:0]       key_code_r;
  logic             key_ext_r;
  logic             key_break_r;
  logic [7:0]       key_ascii_r;
  logic             key_held_r;
  logic [7:0]       held_code_r;
  logic [CNT_W-1:0] make_count_r;
  logic             ovf_sticky_r;

  logic             cand_s;
  logic             match_s;
  logic             emit_s;
  logic [7:0]       ascii_s;

  ps2_scan2ascii u_scan2ascii (
    .ext   (ext_pend_r),
    .code  (byte_r),
    .ascii (ascii_s)
  );

  // Classify the byte being popped and decide whether it produces an event.
  always_comb begin
    cand_s  = 1'b0;
    match_s = 1'b0;
    emit_s  = 1'b0;
    if (state_r == POP) begin
      cand_s = !is_prefix_byte(byte_r) && !is_err_byte(byte_r);
    end else begin
      cand_s = 1'b0;
    end
    match_s = key_held_r && (held_ext_r == ext_pend_r) && (held_code_r == byte_r);
    if (cand_s && !brk_pend_r && SUPPRESS_REPEAT && match_s) begin
      emit_s = 1'b0;
    end else begin
      emit_s = cand_s;
    end
  end

  // Pop handshake FSM: latch head byte, strobe pop for one cycle, let FIFO settle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= IDLE;
      byte_r       <= 8'h00;
      nextdata_n_r <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (ready) begin
            byte_r       <= data;
            nextdata_n_r <= 1'b0;
            state_r      <= POP;
          end else begin
            nextdata_n_r <= 1'b1;
          end
        end
        POP: begin
          nextdata_n_r <= 1'b1;
          state_r      <= WAIT;
        end
        WAIT: begin
          nextdata_n_r <= 1'b1;
          state_r      <= IDLE;
        end
        default: begin
          nextdata_n_r <= 1'b1;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  // Prefix tracking, event outputs, held-key state and overflow latch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ext_pend_r   <= 1'b0;
      brk_pend_r   <= 1'b0;
      held_ext_r   <= 1'b0;
      key_valid_r  <= 1'b0;
      key_code_r   <= 8'h00;
      key_ext_r    <= 1'b0;
      key_break_r  <= 1'b0;
      key_ascii_r  <= 8'h00;
      key_held_r   <= 1'b0;
      held_code_r  <= 8'h00;
      make_count_r <= '0;
      ovf_sticky_r <= 1'b0;
    end else begin
      key_valid_r <= 1'b0;
      if (state_r == POP) begin
        if (byte_r == PS2_EXT) begin
          ext_pend_r <= 1'b1;
        end else if (byte_r == PS2_BRK) begin
          brk_pend_r <= 1'b1;
        end else begin
          ext_pend_r <= 1'b0;
          brk_pend_r <= 1'b0;
        end
      end
      if (emit_s) begin
        key_valid_r <= 1'b1;
        key_code_r  <= byte_r;
        key_ext_r   <= ext_pend_r;
        key_break_r <= brk_pend_r;
        key_ascii_r <= ascii_s;
        if (brk_pend_r) begin
          if (match_s) begin
            key_held_r  <= 1'b0;
            held_code_r <= 8'h00;
            held_ext_r  <= 1'b0;
          end
        end else begin
          key_held_r   <= 1'b1;
          held_code_r  <= byte_r;
          held_ext_r   <= ext_pend_r;
          make_count_r <= make_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      // An overflow means bytes were lost, so any half-assembled prefix is stale.
      if (overflow) begin
        ovf_sticky_r <= 1'b1;
        ext_pend_r   <= 1'b0;
        brk_pend_r   <= 1'b0;
      end
    end
  end

  assign nextdata_n = nextdata_n_r;
  assign key_valid  = key_valid_r;
  assign key_code   = key_code_r;
  assign key_ext    = key_ext_r;
  assign key_break  = key_break_r;
  assign key_ascii  = key_ascii_r;
  assign key_held   = key_held_r;
  assign held_code  = held_code_r;
  assign make_count = make_count_r;
  assign ovf_sticky = ovf_sticky_r;

endmodule
